// File: rtl/slot_wallet.sv
// Credit/bet controller for the slot machine.
// Holds credit and bet, escrows the bet per spin and settles on the reel result.
module slot_wallet #(
    parameter int WIDTH        = 4,
    parameter int MULT_W       = 2,
    parameter int START_CREDIT = 5,
    parameter int MAX_CREDIT   = 9,
    parameter int MAX_BET      = 9,
    parameter int COIN_VALUE   = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bet_up,
    input  logic              bet_dn,
    input  logic              bet_max,
    input  logic              coin,
    input  logic              spin_btn,
    input  logic              result_valid,
    input  logic [MULT_W-1:0] result_mult,
    output logic [WIDTH-1:0]  credit,
    output logic [WIDTH-1:0]  bet,
    output logic [WIDTH-1:0]  last_win,
    output logic              spin_start,
    output logic              spinning,
    output logic              game_over,
    output logic              timeout_err
);

    localparam int PW = WIDTH + MULT_W;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH-1:0] MAXB = WIDTH'(MAX_BET);
    localparam logic [PW:0] MAXW = (PW + 1)'(MAX_CREDIT);
    localparam logic [PW:0] COINW = (PW + 1)'(COIN_VALUE);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SPIN, SETTLE} state_t;

    state_t state, state_nx;
    logic [4:0] btn, btn_q, rise;
    logic [WIDTH-1:0] credit_nx, bet_nx, last_win_nx, bet_cap, base;
    logic [MULT_W-1:0] mult_q, mult_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [PW-1:0] win;
    logic spin_start_nx, timeout_nx, game_over_nx;

    function automatic logic [PW:0] ext(input logic [WIDTH-1:0] v);
        return {{(MULT_W + 1){1'b0}}, v};
    endfunction

    function automatic logic [WIDTH-1:0] sat(input logic [PW:0] v);
        return (v > MAXW) ? MAXW[WIDTH-1:0] : v[WIDTH-1:0];
    endfunction

    assign btn  = {coin, spin_btn, bet_max, bet_dn, bet_up};
    assign rise = btn & ~btn_q;
    assign spinning = (state != IDLE);

    always_comb begin
        state_nx      = state;
        credit_nx     = credit;
        bet_nx        = bet;
        last_win_nx   = last_win;
        mult_nx       = mult_q;
        cnt_nx        = cnt;
        spin_start_nx = 1'b0;
        timeout_nx    = 1'b0;
        base          = credit;
        bet_cap       = (MAXB < credit) ? MAXB : credit;
        win           = {{MULT_W{1'b0}}, bet} * {{WIDTH{1'b0}}, mult_q};
        unique case (state)
            IDLE: begin
                if (rise[3] && bet != '0) begin
                    base          = credit - bet;
                    state_nx      = SPIN;
                    spin_start_nx = 1'b1;
                    cnt_nx        = '0;
                end else if (rise[2]) begin
                    bet_nx = bet_cap;
                end else if (rise[0] && !rise[1]) begin
                    if (bet < bet_cap) bet_nx = bet + 1'b1;
                end else if (rise[1] && !rise[0]) begin
                    if (bet != '0) bet_nx = bet - 1'b1;
                end
                // coin lands after the bet action, on post-escrow credit
                credit_nx = rise[4] ? sat(ext(base) + COINW) : base;
            end
            SPIN: begin
                if (result_valid) begin
                    mult_nx  = result_mult;
                    state_nx = SETTLE;
                end else if (cnt == TLAST) begin
                    credit_nx  = sat(ext(credit) + ext(bet));
                    timeout_nx = 1'b1;
                    state_nx   = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            SETTLE: begin
                credit_nx   = sat(ext(credit) + {1'b0, win});
                last_win_nx = sat({1'b0, win});
                bet_nx      = (bet < credit_nx) ? bet : credit_nx;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        game_over_nx = (state == IDLE) && (credit == '0) && (bet == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            credit      <= WIDTH'(START_CREDIT);
            bet         <= '0;
            last_win    <= '0;
            mult_q      <= '0;
            cnt         <= '0;
            btn_q       <= '0;
            spin_start  <= 1'b0;
            timeout_err <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_nx;
            credit      <= credit_nx;
            bet         <= bet_nx;
            last_win    <= last_win_nx;
            mult_q      <= mult_nx;
            cnt         <= cnt_nx;
            btn_q       <= btn;
            spin_start  <= spin_start_nx;
            timeout_err <= timeout_nx;
            game_over   <= game_over_nx;
        end
    end

endmodule

// File: tb/tb_slot_wallet.sv
// Bench for slot_wallet: directed round script plus randomized buttons,
// all outputs compared every cycle against a spec-level model.
module tb_slot_wallet;

    localparam int START_CREDIT = 5;
    localparam int MAX_CREDIT   = 9;
    localparam int MAX_BET      = 9;
    localparam int COIN_VALUE   = 1;
    localparam int TIMEOUT      = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [4:0] btns = '0;
    logic result_valid = 1'b0;
    logic [1:0] result_mult = '0;
    logic [3:0] credit, bet, last_win;
    logic spin_start, spinning, game_over, timeout_err;

    int tests = 0;
    int fails = 0;

    slot_wallet dut (
        .clk(clk), .rst_n(rst_n),
        .bet_up(btns[0]), .bet_dn(btns[1]), .bet_max(btns[2]),
        .coin(btns[4]), .spin_btn(btns[3]),
        .result_valid(result_valid), .result_mult(result_mult),
        .credit(credit), .bet(bet), .last_win(last_win),
        .spin_start(spin_start), .spinning(spinning),
        .game_over(game_over), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // phase: 0 idle, 1 waiting for reels, 2 settling
    int m_credit, m_bet, m_last, m_phase, m_wait, m_mult, m_win, m_cap;
    bit m_ss, m_to, m_go, m_go_n;
    bit [4:0] m_prev, m_rise;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_credit = START_CREDIT; m_bet = 0; m_last = 0;
            m_phase = 0; m_wait = 0; m_mult = 0;
            m_ss = 0; m_to = 0; m_go = 0; m_prev = '0;
        end else begin
            m_rise = btns & ~m_prev;
            m_prev = btns;
            m_go_n = (m_phase == 0) && (m_credit == 0) && (m_bet == 0);
            m_ss = 0;
            m_to = 0;
            case (m_phase)
                0: begin
                    m_cap = imin(MAX_BET, m_credit);
                    if (m_rise[3] && m_bet > 0) begin
                        m_credit = m_credit - m_bet;
                        m_ss = 1; m_phase = 1; m_wait = 0;
                    end else if (m_rise[2]) begin
                        m_bet = m_cap;
                    end else if (m_rise[0] && !m_rise[1]) begin
                        if (m_bet < m_cap) m_bet++;
                    end else if (m_rise[1] && !m_rise[0]) begin
                        if (m_bet > 0) m_bet--;
                    end
                    if (m_rise[4])
                        m_credit = imin(m_credit + COIN_VALUE, MAX_CREDIT);
                end
                1: begin
                    if (result_valid) begin
                        m_mult = result_mult;
                        m_phase = 2;
                    end else begin
                        m_wait++;
                        if (m_wait == TIMEOUT) begin
                            m_credit = imin(m_credit + m_bet, MAX_CREDIT);
                            m_to = 1; m_phase = 0;
                        end
                    end
                end
                default: begin
                    m_win = m_bet * m_mult;
                    m_last = imin(m_win, MAX_CREDIT);
                    m_credit = imin(m_credit + m_win, MAX_CREDIT);
                    m_bet = imin(m_bet, m_credit);
                    m_phase = 0;
                end
            endcase
            m_go = m_go_n;
        end
    end

    always @(negedge clk) begin
        check("credit", credit, m_credit);
        check("bet", bet, m_bet);
        check("last_win", last_win, m_last);
        check("spin_start", spin_start, m_ss);
        check("spinning", spinning, m_phase != 0);
        check("game_over", game_over, m_go);
        check("timeout_err", timeout_err, m_to);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [4:0] m);
        btns = m; cyc(1);
        btns = '0; cyc(1);
    endtask

    task automatic do_spin(input logic [1:0] mult);
        btns = 5'b01000; cyc(1);
        btns = '0; cyc(1);
        result_valid = 1'b1; result_mult = mult; cyc(1);
        result_valid = 1'b0; cyc(2);
    endtask

    int n;

    initial begin
        #1 rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check("rst_credit", credit, 5);
        check("rst_bet", bet, 0);
        check("rst_game_over", game_over, 0);

        press(5'b00001);
        press(5'b00001);
        btns = 5'b00001; cyc(4);
        btns = '0; cyc(1);
        check("bet3_bet", bet, 3);
        check("bet3_credit", credit, 5);

        btns = 5'b01000; cyc(1);
        check("spin_pulse", spin_start, 1);
        check("escrow_credit", credit, 2);
        check("spinning_hi", spinning, 1);
        btns = '0; cyc(1);
        check("spin_pulse_end", spin_start, 0);
        result_valid = 1'b1; result_mult = 2; cyc(1);
        result_valid = 1'b0; cyc(2);
        check("win6_credit", credit, 8);
        check("win6_last", last_win, 6);
        check("win6_bet", bet, 3);
        check("win6_idle", spinning, 0);

        do_spin(3);
        check("sat_credit", credit, 9);
        check("sat_last", last_win, 9);

        press(5'b00001);
        do_spin(0);
        check("loss4_credit", credit, 5);
        press(5'b00001);
        check("bet5_bet", bet, 5);
        do_spin(0);
        check("bust_credit", credit, 0);
        check("bust_bet", bet, 0);
        check("bust_game_over", game_over, 1);
        press(5'b10000);
        check("coin_credit", credit, 1);
        check("coin_game_over", game_over, 0);

        press(5'b00001);
        btns = 5'b01000; cyc(1);
        btns = '0;
        n = 0;
        while (!timeout_err && n < 400) begin
            cyc(1);
            n++;
        end
        check("timeout_cycles", n, 255);
        check("timeout_credit", credit, 1);
        check("timeout_idle", spinning, 0);
        cyc(1);
        check("timeout_pulse_end", timeout_err, 0);

        press(5'b00011);
        check("updn_bet", bet, 1);
        press(5'b00010);
        check("dn_bet", bet, 0);
        press(5'b01000);
        check("spin_bet0", spinning, 0);
        press(5'b00100);
        check("max_bet", bet, 1);

        btns = 5'b01000; cyc(1);
        btns = '0; cyc(3);
        #1 rst_n = 1'b0;
        #1;
        check("midspin_credit", credit, 5);
        check("midspin_bet", bet, 0);
        check("midspin_spinning", spinning, 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 5; b++)
                if ($urandom_range(3) == 0) btns[b] = ~btns[b];
            if (i >= 2000 && i < 2700)
                result_valid = 1'b0;
            else
                result_valid = ($urandom_range(11) == 0);
            result_mult = 2'($urandom_range(3));
            rst_n = ($urandom_range(999) != 0);
            cyc(1);
        end
        rst_n = 1'b1;
        btns = '0;
        result_valid = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
